score_display_ctrl: RTL and testbench
=====================================

Name: score_display_ctrl

Overview:
- Consumes the single-cycle tick pulses from the clock divider: score tick, fast score tick, display-scan tick and blink tick.
- Keeps the game score as a 4-digit BCD counter and drives the 4-digit multiplexed seven-segment display.
- Blinks the display after game over.
- Sits between the game FSM (run / game_over / clear) and the board display pins.

Parameters:
- DIGITS, 4, number of display digits; fixed at 4 for this revision.
- ACTIVE_LOW, 1, 1 = seg/an/dp_n are driven active-low (board default); 0 = active-high.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous, active-high reset
- score_tick  in  1  one-cycle pulse, 20 Hz
- fast_tick  in  1  one-cycle pulse, 100 Hz
- dp_tick  in  1  one-cycle pulse, display scan rate
- blink_tick  in  1  one-cycle pulse, 2 Hz
- fast_mode  in  1  1 = increment the score on fast_tick instead of score_tick
- run  in  1  level; start counting
- game_over  in  1  pulse or level; freeze the score and start blinking
- clear  in  1  pulse; zero the score and return to IDLE
- seg  out  7  segments {g,f,e,d,c,b,a}
- an  out  4  digit enables; an[0] is the ones digit
- dp_n  out  1  decimal point; always inactive
- score_bcd  out  16  {thousands, hundreds, tens, ones}, 4 bits each
- overflow  out  1  sticky; set when the score saturates

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, score_bcd=0, overflow=0, scan index=0, blink_on=1.
  - seg and an are all inactive (ACTIVE_LOW: seg=7'h7F, an=4'hF); dp_n is inactive.
- States: IDLE, RUN, OVER. Priority each cycle: clear > game_over > run > increment.
  - clear in any state: next state IDLE, score=0, overflow=0, blink_on=1.
  - IDLE -> RUN when run=1. The score is not incremented in the cycle of the transition.
  - RUN -> OVER when game_over=1. Any increment tick in that same cycle is dropped.
  - OVER stays in OVER until clear; run and ticks are ignored.
- Increment:
  - Active only in RUN. The selected tick is fast_tick when fast_mode=1, otherwise score_tick; the other tick is ignored.
  - Score increments by 1 on the clock edge after the cycle in which the selected tick is high.
  - BCD ripple: a digit at 9 becomes 0 and carries into the next digit.
  - At 9999 the score saturates and holds 9999; overflow is set and stays 1 until clear or rst.
- Scan:
  - A 2-bit index advances on each dp_tick and wraps 3->0. It runs in every state, including IDLE.
  - an is one-hot on the index, with polarity set by ACTIVE_LOW.
  - seg is the seven-segment pattern for score digit[index].
  - seg and an are both registered and update together, one cycle after the index changes.
- Leading-zero blanking:
  - Digit i (i>0) is blanked when it and every higher digit are 0. The ones digit is never blanked.
  - A blanked digit keeps its an asserted with seg fully off.
- Blink:
  - In OVER, blink_on toggles on each blink_tick. While blink_on=0, all an are inactive.
  - On entry to OVER, blink_on=1, so the display is visible first.
  - Outside OVER, blink_on is held at 1.
- score_bcd is the register value itself, with no added latency.
- Digit codes 10-15 cannot occur. The decoder maps them to all-segments-off.

Decomposition:
- Shared package:
  - state encoding: IDLE=2'd0, RUN=2'd1, OVER=2'd2.
  - seven-segment constants: SEG_OFF, and the active-high patterns for 0-9.
  - BCD_MAX = 4'd9.
- One sub-module, bcd_to_seg7: combinational, a 4-bit digit and a blank flag in, an active-high 7-bit pattern out. The top level applies the ACTIVE_LOW inversion and the output registers.

Test Plan:
1. Reset then run=1, twenty score_tick pulses, fast_mode=0 -> score_bcd=16'h0020, overflow=0.
2. Preload by ticking to 0099, one more tick -> score_bcd=16'h0100.
   - While scanning: an[3] digit blanked (seg=7'h7F with an[3] low); an[2] shows "1" (seg=7'h79); an[0] shows "0" (seg=7'h40).
3. fast_mode=1, five fast_tick and five score_tick pulses interleaved -> score increases by exactly 5.
4. Drive to 9999, two more ticks -> score_bcd=16'h9999, overflow=1.
   - clear -> score_bcd=0, overflow=0, state IDLE.
5. game_over and score_tick asserted in the same cycle -> score unchanged, state OVER.
   - The blink_tick sequence gives an alternating between scanning and 4'hF on successive ticks.
   - clear restores scanning.
6. Assert rst asynchronously mid-scan, between clock edges -> seg=7'h7F, an=4'hF, score=0 immediately, without waiting for a clk edge.
   - Four dp_tick pulses after release -> an sequence E, D, B, 7.

Source files
------------

// File: rtl/score_display_ctrl_pkg.sv
// Shared types and constants for the score counter / seven-segment display block.
package score_display_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_e;

  // Active-high patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_OFF = 7'h00;
  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;

  localparam logic [3:0]  BCD_MAX   = 4'd9;
  localparam logic [15:0] SCORE_MAX = 16'h9999;

  // Ripple-carry BCD increment; callers handle saturation at SCORE_MAX.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[i*4 +: 4] == BCD_MAX) begin
          r[i*4 +: 4] = '0;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/score_display_ctrl_if.sv
// Control, tick and display signals between the game logic and the score/display block.
interface score_display_ctrl_if;
  logic        score_tick;
  logic        fast_tick;
  logic        dp_tick;
  logic        blink_tick;
  logic        fast_mode;
  logic        run;
  logic        game_over;
  logic        clear;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp_n;
  logic [15:0] score_bcd;
  logic        overflow;

  modport master (
    output score_tick, fast_tick, dp_tick, blink_tick, fast_mode, run, game_over, clear,
    input  seg, an, dp_n, score_bcd, overflow
  );

  modport slave (
    input  score_tick, fast_tick, dp_tick, blink_tick, fast_mode, run, game_over, clear,
    output seg, an, dp_n, score_bcd, overflow
  );
endinterface

// File: rtl/score_display_ctrl_bcd_to_seg7.sv
// Combinational BCD digit to active-high seven-segment pattern, with blanking.
module bcd_to_seg7
  import score_display_ctrl_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    if (!blank) begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_OFF;
      endcase
    end
  end

endmodule

// File: rtl/score_display_ctrl.sv
// Game score BCD counter with a multiplexed 4-digit seven-segment driver and game-over blink.
module score_display_ctrl
  import score_display_ctrl_pkg::*;
#(
  parameter int unsigned DIGITS     = 4,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  score_display_ctrl_if.slave bus
);

  localparam logic [6:0] SEG_IDLE = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0] AN_IDLE  = ACTIVE_LOW ? 4'hF : 4'h0;

  state_e      state_q, state_d;
  logic [15:0] score_q, score_d;
  logic        overflow_q, overflow_d;
  logic [1:0]  idx_q, idx_d;
  logic        blink_on_q, blink_on_d;
  logic [6:0]  seg_q, seg_d;
  logic [3:0]  an_q, an_d;

  logic        inc_tick;
  logic        hi_zero;
  logic [3:0]  blank;
  logic [3:0]  digit;
  logic [6:0]  seg_hi;
  logic [3:0]  an_hi;

  always_comb begin
    inc_tick   = bus.fast_mode ? bus.fast_tick : bus.score_tick;
    state_d    = state_q;
    score_d    = score_q;
    overflow_d = overflow_q;
    blink_on_d = blink_on_q;
    idx_d      = bus.dp_tick ? idx_q + 2'd1 : idx_q;

    if (bus.clear) begin
      state_d    = IDLE;
      score_d    = '0;
      overflow_d = 1'b0;
      blink_on_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          blink_on_d = 1'b1;
          if (bus.run) state_d = RUN;
        end
        RUN: begin
          blink_on_d = 1'b1;
          // game_over wins over a same-cycle tick, so the final score is frozen as-is
          if (bus.game_over) begin
            state_d = OVER;
          end else if (inc_tick) begin
            if (score_q == SCORE_MAX) overflow_d = 1'b1;
            else                      score_d    = bcd_inc(score_q);
          end
        end
        OVER: begin
          if (bus.blink_tick) blink_on_d = ~blink_on_q;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Leading-zero blanking: digit i is blank when it and all higher digits are zero
  always_comb begin
    blank   = '0;
    hi_zero = 1'b1;
    for (int unsigned k = 0; k < DIGITS - 1; k++) begin
      hi_zero = hi_zero & (score_q[(DIGITS-1-k)*4 +: 4] == 4'd0);
      blank[DIGITS-1-k] = hi_zero;
    end
  end

  assign digit = score_q[idx_q*4 +: 4];

  bcd_to_seg7 u_dec (
    .digit (digit),
    .blank (blank[idx_q]),
    .seg   (seg_hi)
  );

  always_comb begin
    an_hi = blink_on_q ? (4'b0001 << idx_q) : 4'b0000;
    seg_d = ACTIVE_LOW ? ~seg_hi : seg_hi;
    an_d  = ACTIVE_LOW ? ~an_hi  : an_hi;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      score_q    <= '0;
      overflow_q <= 1'b0;
      idx_q      <= '0;
      blink_on_q <= 1'b1;
      seg_q      <= SEG_IDLE;
      an_q       <= AN_IDLE;
    end else begin
      state_q    <= state_d;
      score_q    <= score_d;
      overflow_q <= overflow_d;
      idx_q      <= idx_d;
      blink_on_q <= blink_on_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign bus.seg       = seg_q;
  assign bus.an        = an_q;
  assign bus.dp_n      = ACTIVE_LOW;
  assign bus.score_bcd = score_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed self-checking bench for score_display_ctrl (ACTIVE_LOW board default).
module tb_score_display_ctrl;

  logic clk;
  logic rst;
  int   errs;
  int   checks;
  int   bench_idx;

  score_display_ctrl_if bus ();

  score_display_ctrl #(.DIGITS(4), .ACTIVE_LOW(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic hold_score(input int n);
    bus.score_tick = 1'b1;
    repeat (n) @(negedge clk);
    bus.score_tick = 1'b0;
  endtask

  task automatic hold_fast(input int n);
    bus.fast_tick = 1'b1;
    repeat (n) @(negedge clk);
    bus.fast_tick = 1'b0;
  endtask

  task automatic pulse_dp();
    bus.dp_tick = 1'b1;
    @(negedge clk);
    bus.dp_tick = 1'b0;
    bench_idx = (bench_idx + 1) % 4;
  endtask

  task automatic pulse_blink();
    bus.blink_tick = 1'b1;
    @(negedge clk);
    bus.blink_tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
  endtask

  task automatic scan_to(input int target);
    while (bench_idx != target) pulse_dp();
    @(negedge clk);
  endtask

  function automatic logic [3:0] an_exp(input int idx);
    logic [3:0] v;
    v = 4'b0001 << idx;
    return ~v;
  endfunction

  initial begin
    logic [3:0] an_seq [4];
    errs = 0;
    checks = 0;
    bench_idx = 0;
    rst = 1'b1;
    bus.score_tick = 1'b0; bus.fast_tick = 1'b0; bus.dp_tick = 1'b0; bus.blink_tick = 1'b0;
    bus.fast_mode = 1'b0; bus.run = 1'b0; bus.game_over = 1'b0; bus.clear = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_seg", 32'(bus.seg), 32'h7F);
    check("rst_an", 32'(bus.an), 32'hF);
    check("rst_score", 32'(bus.score_bcd), 32'h0);
    check("rst_ovf", 32'(bus.overflow), 32'h0);
    check("rst_dp_n", 32'(bus.dp_n), 32'h1);
    rst = 1'b0;
    @(negedge clk);

    // IDLE->RUN with a tick in the same cycle: no increment
    bus.run = 1'b1;
    hold_score(1);
    check("run_entry_no_inc", 32'(bus.score_bcd), 32'h0);
    hold_score(20);
    check("score_20", 32'(bus.score_bcd), 32'h0020);
    check("ovf_20", 32'(bus.overflow), 32'h0);

    // Ripple carry 0099 -> 0100 and leading-zero blanking
    hold_score(79);
    check("score_99", 32'(bus.score_bcd), 32'h0099);
    hold_score(1);
    check("score_100", 32'(bus.score_bcd), 32'h0100);
    scan_to(0);
    check("an0", 32'(bus.an), 32'hE);
    check("seg_ones_0", 32'(bus.seg), 32'h40);
    scan_to(2);
    check("an2", 32'(bus.an), 32'hB);
    check("seg_hund_1", 32'(bus.seg), 32'h79);
    scan_to(3);
    check("an3_blank", 32'(bus.an), 32'h7);
    check("seg_thou_blank", 32'(bus.seg), 32'h7F);
    scan_to(1);
    check("an1", 32'(bus.an), 32'hD);
    check("seg_tens_0", 32'(bus.seg), 32'h40);

    // fast_mode: only fast_tick counts
    bus.fast_mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      hold_fast(1);
      hold_score(1);
    end
    check("fast_plus5", 32'(bus.score_bcd), 32'h0105);
    bus.fast_mode = 1'b0;
    hold_fast(3);
    check("slow_ignores_fast", 32'(bus.score_bcd), 32'h0105);

    // Saturation at 9999
    hold_score(9894);
    check("score_9999", 32'(bus.score_bcd), 32'h9999);
    hold_score(2);
    check("sat_score", 32'(bus.score_bcd), 32'h9999);
    check("sat_ovf", 32'(bus.overflow), 32'h1);
    bus.run = 1'b0;
    pulse_clear();
    check("clr_score", 32'(bus.score_bcd), 32'h0);
    check("clr_ovf", 32'(bus.overflow), 32'h0);
    hold_score(3);
    check("idle_no_count", 32'(bus.score_bcd), 32'h0);

    // game_over with a same-cycle tick, then blink
    bus.run = 1'b1;
    @(negedge clk);
    hold_score(5);
    check("score_5", 32'(bus.score_bcd), 32'h0005);
    bus.game_over = 1'b1;
    hold_score(1);
    bus.game_over = 1'b0;
    check("gameover_drop_tick", 32'(bus.score_bcd), 32'h0005);
    hold_score(3);
    check("over_frozen", 32'(bus.score_bcd), 32'h0005);
    @(negedge clk);
    check("over_visible", 32'(bus.an), 32'(an_exp(bench_idx)));
    pulse_blink();
    check("blink_off", 32'(bus.an), 32'hF);
    pulse_blink();
    check("blink_on", 32'(bus.an), 32'(an_exp(bench_idx)));
    pulse_blink();
    check("blink_off2", 32'(bus.an), 32'hF);
    bus.run = 1'b0;
    pulse_clear();
    @(negedge clk);
    check("clr_restores_scan", 32'(bus.an), 32'(an_exp(bench_idx)));
    check("clr_over_score", 32'(bus.score_bcd), 32'h0);

    // Asynchronous reset between clock edges
    bus.run = 1'b1;
    @(negedge clk);
    hold_score(7);
    scan_to(2);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_seg", 32'(bus.seg), 32'h7F);
    check("async_an", 32'(bus.an), 32'hF);
    check("async_score", 32'(bus.score_bcd), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bench_idx = 0;
    @(negedge clk);
    check("post_rst_an0", 32'(bus.an), 32'hE);
    an_seq[0] = 4'hD; an_seq[1] = 4'hB; an_seq[2] = 4'h7; an_seq[3] = 4'hE;
    for (int i = 0; i < 4; i++) begin
      pulse_dp();
      @(negedge clk);
      check($sformatf("scan_seq%0d", i), 32'(bus.an), 32'(an_seq[i]));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
